gtx_tx_sync_seq: RTL and testbench
==================================

GTX_TX_SYNC_SEQ -- requirements
Module: gtx_tx_sync_seq

Interface
REQ-001 The block SHALL run on one clock with a synchronous, active-low reset: ports CLK and RST_N.
REQ-002 The block SHALL provide the following parameters (name, default, meaning):
- ALIGN_WAIT, 512: cycles TXENPMAPHASEALIGN is held before TXPMASETPHASE asserts; legal range 2..16383.
- SETPHASE_CYC, 8192: cycles TXPMASETPHASE is held high; legal range 2..16383.
- RSTDONE_TMO, 16383: cycles without TX_RESETDONE before SYNC_ERR is flagged; legal range 2..16383.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1: TX user clock.
- RST_N, in, 1: synchronous active-low reset.
- GTX_RST, in, 1: GTX held in reset, driven by the trigger-clock start FSM.
- TX_RESETDONE, in, 1: GTX TX reset complete.
- RESTART, in, 1: single-cycle request to redo phase alignment.
- TXENPMAPHASEALIGN, out, 1: GTX PMA phase-align enable.
- TXPMASETPHASE, out, 1: GTX PMA set-phase strobe.
- SYNC_DONE, out, 1: alignment complete; feeds the start FSM's SYNC_DONE input.
- SYNC_ERR, out, 1: sticky TX_RESETDONE timeout flag.

Function
REQ-004 The state machine SHALL have the states IDLE, WAIT_RSTDONE, ALIGN_EN, SET_PHASE and DONE, with one shared 14-bit counter.
REQ-005 Outputs SHALL be registered and decoded from the next state, so they change on the same edge as the state.
- TXENPMAPHASEALIGN = 1 in ALIGN_EN, SET_PHASE and DONE.
- TXPMASETPHASE = 1 in SET_PHASE only.
- SYNC_DONE = 1 in DONE only.
REQ-006 GTX_RST=1 in any state SHALL force next state IDLE and clear the counter; this has priority over all other inputs except RST_N.
REQ-007 IDLE SHALL go to WAIT_RSTDONE when GTX_RST=0, clearing the counter.
REQ-008 WAIT_RSTDONE SHALL behave as follows:
- TX_RESETDONE=1 -> ALIGN_EN, counter cleared.
- Otherwise the counter increments; at RSTDONE_TMO-1 it SHALL set SYNC_ERR, wrap to 0 and stay in WAIT_RSTDONE.
REQ-009 ALIGN_EN SHALL count to ALIGN_WAIT-1, then go to SET_PHASE with the counter cleared.
REQ-010 SET_PHASE SHALL count to SETPHASE_CYC-1, then go to DONE.
REQ-011 Latency: SYNC_DONE SHALL rise exactly ALIGN_WAIT+SETPHASE_CYC cycles after TXENPMAPHASEALIGN rises.
REQ-012 DONE SHALL behave as follows:
- TX_RESETDONE=0 -> WAIT_RSTDONE, counter cleared.
- Else RESTART=1 -> ALIGN_EN, counter cleared.
- Else stay in DONE.
REQ-013 RESTART=1 while in ALIGN_EN or SET_PHASE SHALL re-enter ALIGN_EN with the counter cleared. RESTART SHALL be ignored in IDLE and WAIT_RSTDONE.
REQ-014 TX_RESETDONE falling while in ALIGN_EN or SET_PHASE SHALL return the block to WAIT_RSTDONE with the counter cleared.
REQ-015 SYNC_ERR SHALL clear on reset or on a RESTART pulse; when a timeout and a RESTART occur in the same cycle, set wins.
REQ-016 Any unused or illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-017 When RST_N=0 at a CLK edge, the block SHALL go to IDLE, clear the counter, and drive TXENPMAPHASEALIGN=0, TXPMASETPHASE=0, SYNC_DONE=0 and SYNC_ERR=0.
REQ-018 Reset SHALL be honoured mid-sequence with the same values; there is no asynchronous path.

Configuration
REQ-019 With macro GTX_TX_SYNC_TMR_EN defined, the block SHALL triplicate the following, each copy computing its next state from the majority-voted state:
- the state register, the counter, and all four output registers;
- outputs are the 2-of-3 majority of their three copies.
REQ-020 Without GTX_TX_SYNC_TMR_EN, the block SHALL use a single copy of each register. Port-level behaviour SHALL be identical in both builds.

Structure
REQ-021 A shared package SHALL hold the state encoding constants and the 14-bit counter width constant.
REQ-022 A sub-module maj3 (parameterised-width 2-of-3 voter) SHALL be used only in the TMR build.

Verification (ALIGN_WAIT=4, SETPHASE_CYC=8, RSTDONE_TMO=16)
REQ-023 Nominal sequence: RST_N=0 for 2 cycles, then GTX_RST=0 and TX_RESETDONE=1 -> TXENPMAPHASEALIGN high, TXPMASETPHASE high exactly 4 cycles later for 8 cycles, then SYNC_DONE=1.
REQ-024 Timeout: TX_RESETDONE held 0 for 16 cycles -> SYNC_ERR=1 and stays 1; a RESTART pulse then clears it.
REQ-025 GTX_RST pulse during SET_PHASE -> all outputs 0 the following cycle; the sequence restarts from IDLE once GTX_RST=0.
REQ-026 In DONE, RESTART and TX_RESETDONE fall in the same cycle -> state WAIT_RSTDONE and SYNC_DONE=0.
REQ-027 RST_N=0 during ALIGN_EN -> all outputs 0 next edge. In the TMR build, corrupting one state copy mid-run leaves outputs undisturbed.

Source files
------------

// File: rtl/gtx_tx_sync_seq_pkg.sv
// Shared constants for the GTX TX phase-alignment sequencer: state encoding,
// counter width and the registered-state bundle that is triplicated in the TMR build.
package gtx_tx_sync_seq_pkg;

  localparam int CNT_W = 14;

  // Encodings are kept as plain constants so they match the legacy netlists.
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WAIT_RSTDONE = 3'd1;
  localparam logic [2:0] ST_ALIGN_EN     = 3'd2;
  localparam logic [2:0] ST_SET_PHASE    = 3'd3;
  localparam logic [2:0] ST_DONE         = 3'd4;

  typedef struct packed {
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             align_en;
    logic             set_phase;
    logic             done;
    logic             err;
  } seq_regs_t;

  localparam seq_regs_t SEQ_REGS_RST = '{
    state:     ST_IDLE,
    cnt:       '0,
    align_en:  1'b0,
    set_phase: 1'b0,
    done:      1'b0,
    err:       1'b0
  };

  // Terminal count for a phase lasting `cycles` clocks.
  function automatic logic [CNT_W-1:0] last_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/gtx_tx_sync_seq_if.sv
// Control bundle between the TX sync sequencer, the GTX transceiver and the
// trigger-clock start FSM.
interface gtx_tx_sync_seq_if;

  logic GTX_RST;
  logic TX_RESETDONE;
  logic RESTART;
  logic TXENPMAPHASEALIGN;
  logic TXPMASETPHASE;
  logic SYNC_DONE;
  logic SYNC_ERR;

  modport master (
    input  GTX_RST,
    input  TX_RESETDONE,
    input  RESTART,
    output TXENPMAPHASEALIGN,
    output TXPMASETPHASE,
    output SYNC_DONE,
    output SYNC_ERR
  );

  modport slave (
    output GTX_RST,
    output TX_RESETDONE,
    output RESTART,
    input  TXENPMAPHASEALIGN,
    input  TXPMASETPHASE,
    input  SYNC_DONE,
    input  SYNC_ERR
  );

endinterface

// File: rtl/gtx_tx_sync_seq_maj3.sv
// Bitwise 2-of-3 majority voter used to resolve the triplicated sequencer state.
module maj3 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/gtx_tx_sync_seq.sv
// GTX TX PMA phase-alignment sequencer. Define GTX_TX_SYNC_TMR_EN to triplicate
// every register with 2-of-3 voting; port behaviour is the same in both builds.
module gtx_tx_sync_seq #(
  parameter int ALIGN_WAIT   = 512,
  parameter int SETPHASE_CYC = 8192,
  parameter int RSTDONE_TMO  = 16383
) (
  input  logic              CLK,
  input  logic              RST_N,
  gtx_tx_sync_seq_if.master bus
);

  import gtx_tx_sync_seq_pkg::*;

  localparam logic [CNT_W-1:0] ALIGN_LAST = last_count(ALIGN_WAIT);
  localparam logic [CNT_W-1:0] SET_LAST   = last_count(SETPHASE_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST   = last_count(RSTDONE_TMO);

  seq_regs_t        cur;
  seq_regs_t        nxt;
  logic [2:0]       nxt_state;
  logic [CNT_W-1:0] nxt_cnt;
  logic             timeout;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    nxt_state = ST_IDLE;
    nxt_cnt   = '0;
    timeout   = 1'b0;
    if (!bus.GTX_RST) begin
      case (cur.state)
        ST_IDLE: nxt_state = ST_WAIT_RSTDONE;

        ST_WAIT_RSTDONE: begin
          if (bus.TX_RESETDONE) begin
            nxt_state = ST_ALIGN_EN;
          end else begin
            nxt_state = ST_WAIT_RSTDONE;
            if (cur.cnt == TMO_LAST) timeout = 1'b1;
            else                     nxt_cnt = cur.cnt + 1'b1;
          end
        end

        // Losing TX_RESETDONE outranks RESTART in every aligning state.
        ST_ALIGN_EN: begin
          if (!bus.TX_RESETDONE)          nxt_state = ST_WAIT_RSTDONE;
          else if (bus.RESTART)           nxt_state = ST_ALIGN_EN;
          else if (cur.cnt == ALIGN_LAST) nxt_state = ST_SET_PHASE;
          else begin
            nxt_state = ST_ALIGN_EN;
            nxt_cnt   = cur.cnt + 1'b1;
          end
        end

        ST_SET_PHASE: begin
          if (!bus.TX_RESETDONE)        nxt_state = ST_WAIT_RSTDONE;
          else if (bus.RESTART)         nxt_state = ST_ALIGN_EN;
          else if (cur.cnt == SET_LAST) nxt_state = ST_DONE;
          else begin
            nxt_state = ST_SET_PHASE;
            nxt_cnt   = cur.cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (!bus.TX_RESETDONE) nxt_state = ST_WAIT_RSTDONE;
          else if (bus.RESTART)  nxt_state = ST_ALIGN_EN;
          else                   nxt_state = ST_DONE;
        end

        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as it.
  always_comb begin
    nxt           = SEQ_REGS_RST;
    nxt.state     = nxt_state;
    nxt.cnt       = nxt_cnt;
    nxt.align_en  = (nxt_state == ST_ALIGN_EN) || (nxt_state == ST_SET_PHASE) ||
                    (nxt_state == ST_DONE);
    nxt.set_phase = (nxt_state == ST_SET_PHASE);
    nxt.done      = (nxt_state == ST_DONE);
    nxt.err       = timeout | (cur.err & ~bus.RESTART);
  end

`ifdef GTX_TX_SYNC_TMR_EN
  seq_regs_t                     copy0_q;
  seq_regs_t                     copy1_q;
  seq_regs_t                     copy2_q;
  logic [$bits(seq_regs_t)-1:0] voted;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      copy0_q <= SEQ_REGS_RST;
      copy1_q <= SEQ_REGS_RST;
      copy2_q <= SEQ_REGS_RST;
    end else begin
      copy0_q <= nxt;
      copy1_q <= nxt;
      copy2_q <= nxt;
    end
  end

  // All copies reload from the voted value, so a single upset is scrubbed next edge.
  maj3 #(
    .WIDTH ($bits(seq_regs_t))
  ) u_vote (
    .a (copy0_q),
    .b (copy1_q),
    .c (copy2_q),
    .y (voted)
  );

  assign cur = seq_regs_t'(voted);
`else
  seq_regs_t regs_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) regs_q <= SEQ_REGS_RST;
    else        regs_q <= nxt;
  end

  assign cur = regs_q;
`endif

  assign bus.TXENPMAPHASEALIGN = cur.align_en;
  assign bus.TXPMASETPHASE     = cur.set_phase;
  assign bus.SYNC_DONE         = cur.done;
  assign bus.SYNC_ERR          = cur.err;

endmodule

// File: tb/tb_gtx_tx_sync_seq.sv
// Self-checking bench for gtx_tx_sync_seq: directed scenarios followed by a
// random phase, all compared against a timeline-based reference model.
module tb_gtx_tx_sync_seq;

  localparam int AW  = 4;
  localparam int SC  = 8;
  localparam int TMO = 16;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_SEQ  = 2;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;

  gtx_tx_sync_seq_if bus ();

  gtx_tx_sync_seq #(
    .ALIGN_WAIT   (AW),
    .SETPHASE_CYC (SC),
    .RSTDONE_TMO  (TMO)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: where the link is (idle / waiting for reset-done / in the
  // alignment timeline), how long it has been there, and the sticky error flag.
  int   m_mode = M_IDLE;
  int   m_seq  = 0;
  int   m_wait = 0;
  logic m_err  = 1'b0;

  int   cycle   = 0;
  int   en_rise = -1;
  int   dn_rise = -1;
  logic prev_en = 1'b0;
  logic prev_dn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_update(input logic rn, input logic gr, input logic rd, input logic rs);
    logic tmo;
    tmo = 1'b0;
    if (!rn) begin
      m_mode = M_IDLE;
      m_seq  = 0;
      m_wait = 0;
      m_err  = 1'b0;
    end else begin
      if (gr) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: begin m_mode = M_WAIT; m_wait = 0; end
          M_WAIT: begin
            if (rd) begin
              m_mode = M_SEQ;
              m_seq  = 0;
            end else begin
              m_wait++;
              if (m_wait == TMO) begin tmo = 1'b1; m_wait = 0; end
            end
          end
          default: begin
            if (!rd)             begin m_mode = M_WAIT; m_wait = 0; end
            else if (rs)         m_seq = 0;
            else if (m_seq < AW + SC) m_seq++;
          end
        endcase
      end
      m_err = tmo | (m_err & ~rs);
    end
  endtask

  task automatic step(input logic rn, input logic gr, input logic rd, input logic rs);
    logic e_en, e_sp, e_dn;
    @(negedge CLK);
    RST_N            = rn;
    bus.GTX_RST      = gr;
    bus.TX_RESETDONE = rd;
    bus.RESTART      = rs;
    @(posedge CLK);
    model_update(rn, gr, rd, rs);
    cycle++;
    #1;
    e_en = (m_mode == M_SEQ);
    e_sp = (m_mode == M_SEQ) && (m_seq >= AW) && (m_seq < AW + SC);
    e_dn = (m_mode == M_SEQ) && (m_seq == AW + SC);
    check("txenpmaphasealign", 32'(bus.TXENPMAPHASEALIGN), 32'(e_en));
    check("txpmasetphase",     32'(bus.TXPMASETPHASE),     32'(e_sp));
    check("sync_done",         32'(bus.SYNC_DONE),         32'(e_dn));
    check("sync_err",          32'(bus.SYNC_ERR),          32'(m_err));
    if (bus.TXENPMAPHASEALIGN && !prev_en) en_rise = cycle;
    if (bus.SYNC_DONE && !prev_dn)         dn_rise = cycle;
    prev_en = bus.TXENPMAPHASEALIGN;
    prev_dn = bus.SYNC_DONE;
  endtask

  initial begin
    logic rd;
    RST_N            = 1'b0;
    bus.GTX_RST      = 1'b1;
    bus.TX_RESETDONE = 1'b0;
    bus.RESTART      = 1'b0;

    // Reset for two cycles, then the nominal alignment sequence.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0);
    check("nominal_done_reached", 32'(bus.SYNC_DONE), 32'd1);
    check("align_to_done_latency", 32'(dn_rise - en_rise), 32'(AW + SC));

    // RESTART and TX_RESETDONE falling together in DONE: reset-done loss wins.
    step(1, 0, 0, 1);
    check("done_restart_rdfall", 32'(bus.SYNC_DONE), 32'd0);

    // Timeout: error sets and sticks, then a RESTART pulse clears it.
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0);
    check("timeout_sticky", 32'(bus.SYNC_ERR), 32'd1);
    step(1, 0, 0, 1);
    check("restart_clears_err", 32'(bus.SYNC_ERR), 32'd0);

    // GTX_RST pulse during SET_PHASE drops every output, then the sequence reruns.
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0);
    check("in_set_phase", 32'(bus.TXPMASETPHASE), 32'd1);
    step(1, 1, 1, 0);
    check("gtxrst_en_low", 32'(bus.TXENPMAPHASEALIGN), 32'd0);
    check("gtxrst_sp_low", 32'(bus.TXPMASETPHASE), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0);
    check("rerun_done", 32'(bus.SYNC_DONE), 32'd1);

    // Synchronous reset while in ALIGN_EN.
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    check("rst_in_align_en", 32'(bus.TXENPMAPHASEALIGN), 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);

    // Random traffic with a slowly toggling TX_RESETDONE.
    rd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(19) == 0) rd = ~rd;
      step(logic'($urandom_range(63) != 0), logic'($urandom_range(31) == 0),
           rd, logic'($urandom_range(15) == 0));
    end

`ifdef GTX_TX_SYNC_TMR_EN
    // Upset one copy mid-sequence; the voted outputs must not notice.
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    force dut.copy1_q = '1;
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    release dut.copy1_q;
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
